// File: rtl/display_dec_scan.sv
// Binary-to-BCD (shift-add-3) converter feeding a multiplexed seven-segment bank.
// Optional leading-zero blanking is enabled by defining DISPLAY_BLANK_EN.
module display_dec_scan #(
    parameter int DIGITS   = 4,
    parameter int BIN_W    = 13,
    parameter int SCAN_DIV = 1
) (
    input  logic              display_clk,
    input  logic              reset,
    input  logic [BIN_W-1:0]  num_bin,
    input  logic              load,
    output logic              busy,
    output logic              overflow,
    output logic [6:0]        sseg,
    output logic [DIGITS-1:0] sel
);
    localparam int BCD_W  = 4 * DIGITS;
    localparam int STEP_W = $clog2(BIN_W + 1);
    localparam int PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_ZERO = 7'b0111111;

    logic [BIN_W-1:0]  bin_reg;
    logic [BCD_W-1:0]  work_bcd_reg;
    logic              work_ovf_reg;
    logic [STEP_W-1:0] step_reg;
    logic              busy_reg;
    logic [BCD_W-1:0]  disp_bcd_reg;
    logic              ovf_reg;
    logic [PRE_W-1:0]  pre_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [DIGITS-1:0] sel_reg;
    logic [6:0]        sseg_reg;

    logic [BCD_W-1:0]  adj_bcd;
    logic [BCD_W-1:0]  shift_bcd_next;
    logic              shift_out;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign adj_bcd[4*gi +: 4] = (work_bcd_reg[4*gi +: 4] >= 4'd5) ?
                                        work_bcd_reg[4*gi +: 4] + 4'd3 :
                                        work_bcd_reg[4*gi +: 4];
        end
    endgenerate

    assign shift_out      = adj_bcd[BCD_W-1];
    assign shift_bcd_next = {adj_bcd[BCD_W-2:0], bin_reg[BIN_W-1]};

    always_ff @(posedge display_clk or posedge reset) begin
        if (reset) begin
            bin_reg      <= '0;
            work_bcd_reg <= '0;
            work_ovf_reg <= 1'b0;
            step_reg     <= '0;
            busy_reg     <= 1'b0;
            disp_bcd_reg <= '0;
            ovf_reg      <= 1'b0;
        end else if (!busy_reg) begin
            if (load) begin
                bin_reg      <= num_bin;
                work_bcd_reg <= '0;
                work_ovf_reg <= 1'b0;
                step_reg     <= STEP_W'(BIN_W);
                busy_reg     <= 1'b1;
            end
        end else begin
            bin_reg      <= bin_reg << 1;
            work_bcd_reg <= shift_bcd_next;
            work_ovf_reg <= work_ovf_reg | shift_out;
            step_reg     <= step_reg - STEP_W'(1);
            // Last step: commit the freshly shifted value, not the stale working copy.
            if (step_reg == STEP_W'(1)) begin
                disp_bcd_reg <= shift_bcd_next;
                ovf_reg      <= work_ovf_reg | shift_out;
                busy_reg     <= 1'b0;
            end
        end
    end

    function automatic logic [6:0] dec7(input logic [3:0] nib);
        case (nib)
            4'd0:    dec7 = 7'h3f;
            4'd1:    dec7 = 7'h06;
            4'd2:    dec7 = 7'h5b;
            4'd3:    dec7 = 7'h4f;
            4'd4:    dec7 = 7'h66;
            4'd5:    dec7 = 7'h6d;
            4'd6:    dec7 = 7'h7d;
            4'd7:    dec7 = 7'h07;
            4'd8:    dec7 = 7'h7f;
            4'd9:    dec7 = 7'h6f;
            default: dec7 = 7'h3f;
        endcase
    endfunction

    logic [3:0]        digit_nib;
    logic              blank_digit;
    logic [6:0]        sseg_next;
    logic [DIGITS-1:0] sel_next;

    assign digit_nib = disp_bcd_reg[{idx_reg, 2'b00} +: 4];

`ifdef DISPLAY_BLANK_EN
    // lz[i] is set when digit i and every digit above it are zero.
    logic [DIGITS-1:0] lz;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_lz
            if (gi == DIGITS - 1) begin : g_top
                assign lz[gi] = (disp_bcd_reg[4*gi +: 4] == 4'd0);
            end else begin : g_low
                assign lz[gi] = (disp_bcd_reg[4*gi +: 4] == 4'd0) && lz[gi+1];
            end
        end
    endgenerate
    assign blank_digit = (idx_reg != '0) && lz[idx_reg];
`else
    assign blank_digit = 1'b0;
`endif

    always_comb begin
        sel_next          = '0;
        sel_next[idx_reg] = 1'b1;
        if (ovf_reg)
            sseg_next = SEG_DASH;
        else if (blank_digit)
            sseg_next = 7'h00;
        else
            sseg_next = dec7(digit_nib);
    end

    always_ff @(posedge display_clk or posedge reset) begin
        if (reset) begin
            pre_reg  <= '0;
            idx_reg  <= '0;
            sel_reg  <= DIGITS'(1);
            sseg_reg <= SEG_ZERO;
        end else begin
            sel_reg  <= sel_next;
            sseg_reg <= sseg_next;
            if (pre_reg == PRE_W'(SCAN_DIV - 1)) begin
                pre_reg <= '0;
                idx_reg <= (idx_reg == IDX_W'(DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);
            end else begin
                pre_reg <= pre_reg + PRE_W'(1);
            end
        end
    end

    assign busy     = busy_reg;
    assign overflow = ovf_reg;
    assign sseg     = sseg_reg;
    assign sel      = sel_reg;
endmodule

// File: tb/tb_display_dec_scan.sv
// Directed bench for display_dec_scan: three instances (defaults, 3-digit/10-bit, SCAN_DIV=3).
module tb_display_dec_scan;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        load_a, load_b, load_c;
    logic [12:0] num_a, num_c;
    logic [9:0]  num_b;
    logic        busy_a, busy_b, busy_c;
    logic        ovf_a, ovf_b, ovf_c;
    logic [6:0]  sseg_a, sseg_b, sseg_c;
    logic [3:0]  sel_a, sel_c;
    logic [2:0]  sel_b;

    int total = 0;
    int bad   = 0;

`ifdef DISPLAY_BLANK_EN
    localparam logic [6:0] Z = 7'h00;
`else
    localparam logic [6:0] Z = 7'h3f;
`endif

    display_dec_scan dut_a (
        .display_clk(clk), .reset(reset), .num_bin(num_a), .load(load_a),
        .busy(busy_a), .overflow(ovf_a), .sseg(sseg_a), .sel(sel_a));

    display_dec_scan #(.DIGITS(3), .BIN_W(10), .SCAN_DIV(1)) dut_b (
        .display_clk(clk), .reset(reset), .num_bin(num_b), .load(load_b),
        .busy(busy_b), .overflow(ovf_b), .sseg(sseg_b), .sel(sel_b));

    display_dec_scan #(.DIGITS(4), .BIN_W(13), .SCAN_DIV(3)) dut_c (
        .display_clk(clk), .reset(reset), .num_bin(num_c), .load(load_c),
        .busy(busy_c), .overflow(ovf_c), .sseg(sseg_c), .sel(sel_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sel_of(input int w);
        case (w)
            0:       sel_of = 32'(sel_a);
            1:       sel_of = 32'(sel_b);
            default: sel_of = 32'(sel_c);
        endcase
    endfunction

    function automatic logic [31:0] seg_of(input int w);
        case (w)
            0:       seg_of = 32'(sseg_a);
            1:       seg_of = 32'(sseg_b);
            default: seg_of = 32'(sseg_c);
        endcase
    endfunction

    function automatic logic busy_of(input int w);
        case (w)
            0:       busy_of = busy_a;
            1:       busy_of = busy_b;
            default: busy_of = busy_c;
        endcase
    endfunction

    // Wait (bounded) for digit i to be selected, then check its segments.
    task automatic check_digit(input int w, input int i, input logic [6:0] exp, input string tag);
        int n = 0;
        while (sel_of(w) !== (32'd1 << i) && n < 40) begin
            tick;
            n++;
        end
        chk({tag, "_sel"}, sel_of(w), 32'd1 << i);
        chk(tag, seg_of(w), 32'(exp));
    endtask

    task automatic do_load(input int w, input logic [12:0] v, input int exp_cycles,
                           input bit pulse, input string tag);
        int n = 0;
        case (w)
            0: begin load_a = 1'b1; num_a = v; end
            1: begin load_b = 1'b1; num_b = v[9:0]; end
            default: begin load_c = 1'b1; num_c = v; end
        endcase
        tick;
        load_a = 1'b0; load_b = 1'b0; load_c = 1'b0;
        chk({tag, "_busy_start"}, 32'(busy_of(w)), 32'd1);
        while (busy_of(w) && n < 60) begin
            if (pulse && n == 4) begin
                load_a = 1'b1;
                num_a  = 13'd9999;
            end else begin
                load_a = 1'b0;
            end
            tick;
            n++;
        end
        load_a = 1'b0;
        chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_cycles));
        tick;
    endtask

    initial begin
        logic [3:0] prev;
        int         n;
        reset  = 1'b1;
        load_a = 1'b0; load_b = 1'b0; load_c = 1'b0;
        num_a  = '0;   num_b  = '0;   num_c  = '0;
        tick;
        tick;
        chk("rst_sel", 32'(sel_a), 32'h1);
        chk("rst_sseg", 32'(sseg_a), 32'h3f);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_ovf", 32'(ovf_a), 32'd0);
        reset = 1'b0;

        // Scan order after reset: 0001,0010,0100,1000,0001.
        tick; chk("scan0_sel", 32'(sel_a), 32'h1); chk("scan0_seg", 32'(sseg_a), 32'h3f);
        tick; chk("scan1_sel", 32'(sel_a), 32'h2); chk("scan1_seg", 32'(sseg_a), 32'(Z));
        tick; chk("scan2_sel", 32'(sel_a), 32'h4); chk("scan2_seg", 32'(sseg_a), 32'(Z));
        tick; chk("scan3_sel", 32'(sel_a), 32'h8); chk("scan3_seg", 32'(sseg_a), 32'(Z));
        tick; chk("scan4_sel", 32'(sel_a), 32'h1); chk("scan4_seg", 32'(sseg_a), 32'h3f);

        // 1234 with an ignored mid-conversion load of 9999.
        do_load(0, 13'd1234, 13, 1'b1, "ld1234");
        chk("ld1234_ovf", 32'(ovf_a), 32'd0);
        check_digit(0, 0, 7'h66, "d1234_0");
        check_digit(0, 1, 7'h4f, "d1234_1");
        check_digit(0, 2, 7'h5b, "d1234_2");
        check_digit(0, 3, 7'h06, "d1234_3");

        do_load(0, 13'd7, 13, 1'b0, "ld7");
        check_digit(0, 0, 7'h07, "d7_0");
        check_digit(0, 1, Z, "d7_1");
        check_digit(0, 2, Z, "d7_2");
        check_digit(0, 3, Z, "d7_3");

        do_load(0, 13'd8191, 13, 1'b0, "ld8191");
        check_digit(0, 0, 7'h06, "d8191_0");
        check_digit(0, 1, 7'h6f, "d8191_1");
        check_digit(0, 2, 7'h06, "d8191_2");
        check_digit(0, 3, 7'h7f, "d8191_3");

        // Three-digit instance: overflow dashes, then recovery.
        do_load(1, 13'd1000, 10, 1'b0, "ld1000");
        chk("ld1000_ovf", 32'(ovf_b), 32'd1);
        check_digit(1, 0, 7'h40, "d1000_0");
        check_digit(1, 1, 7'h40, "d1000_1");
        check_digit(1, 2, 7'h40, "d1000_2");
        do_load(1, 13'd999, 10, 1'b0, "ld999");
        chk("ld999_ovf", 32'(ovf_b), 32'd0);
        check_digit(1, 0, 7'h6f, "d999_0");
        check_digit(1, 1, 7'h6f, "d999_1");
        check_digit(1, 2, 7'h6f, "d999_2");

        // SCAN_DIV=3: each select pattern held for exactly 3 cycles.
        prev = sel_c;
        n = 0;
        while (sel_c === prev && n < 20) begin tick; n++; end
        for (int k = 0; k < 4; k++) begin
            prev = sel_c;
            n = 0;
            while (sel_c === prev && n < 20) begin tick; n++; end
            chk($sformatf("hold%0d", k), 32'(n), 32'd3);
            chk($sformatf("next%0d", k), 32'(sel_c), 32'({prev[2:0], prev[3]}));
        end

        // Reset during conversion aborts without committing.
        load_a = 1'b1; num_a = 13'd4321;
        tick;
        load_a = 1'b0;
        repeat (5) tick;
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy_a), 32'd0);
        chk("abort_sel", 32'(sel_a), 32'h1);
        chk("abort_sseg", 32'(sseg_a), 32'h3f);
        chk("abort_ovf", 32'(ovf_a), 32'd0);
        tick;
        reset = 1'b0;
        repeat (14) tick;
        chk("abort_idle", 32'(busy_a), 32'd0);
        check_digit(0, 0, 7'h3f, "dab_0");
        check_digit(0, 1, Z, "dab_1");
        check_digit(0, 3, Z, "dab_3");

        do_load(0, 13'd42, 13, 1'b0, "ld42");
        check_digit(0, 0, 7'h5b, "d42_0");
        check_digit(0, 1, 7'h66, "d42_1");
        check_digit(0, 2, Z, "d42_2");
        check_digit(0, 3, Z, "d42_3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/display_dec_scan.md
# display_dec_scan

Parametrised successor to the fixed four-digit left-bank display driver: converts an unsigned binary value into `DIGITS` BCD digits and time-multiplexes them onto one common-segment seven-segment bank. Conversion is a sequential shift-add-3 (double-dabble) engine with a load/busy handshake, not combinational division. The block sits between the datapath value source and the board segment/select pins, clocked by the 10 kHz display clock.

## Interface
- `DIGITS`, 4: number of digits and select lines (≥1).
- `BIN_W`, 13: width of the binary input (≥1).
- `SCAN_DIV`, 1: `display_clk` cycles each digit stays selected (≥1).
- `display_clk` input 1: display clock, rising-edge active.
- `reset` input 1: asynchronous, active-high reset.
- `num_bin` input `BIN_W`: unsigned value to show, sampled only on an accepted load.
- `load` input 1: start conversion request, level-sampled each edge.
- `busy` output 1: conversion in progress; load is ignored while high.
- `overflow` output 1: last committed value did not fit in `DIGITS` decimal digits.
- `sseg` output 7: segments, active-high, bit0=a … bit6=g.
- `sel` output `DIGITS`: one-hot digit select, active-high, `sel[0]` is the least significant digit.

## Operation
- Reset: display BCD register = 0, `overflow`=0, `busy`=0, scan index=0, prescaler=0, `sel`=1 (only bit 0 set), `sseg`=7'b0111111 ("0").
- Accept: `load`=1 and `busy`=0 at an edge → capture `num_bin` into the shift register, clear the working BCD and the overflow flag, set the step counter to `BIN_W`, and set `busy`.
- Each following edge: add 3 to every working BCD nibble ≥5, then shift {BCD, binary} left by one. If a 1 is shifted out of the top nibble, set the working overflow flag. Decrement the step counter.
- After step `BIN_W`: commit the working BCD and overflow flag to the display register on the same edge, and clear `busy`.
- The display register changes only at commit. The previous value stays on screen throughout a conversion.
- `load` while `busy`=1 is ignored and not queued.
- Scan: the prescaler counts 0..`SCAN_DIV`-1. When it wraps, the index advances, and it wraps from `DIGITS`-1 to 0.
- Decode, digits 0–9: 3f,06,5b,4f,66,6d,7d,07,7f,6f. Nibbles ≥10 cannot occur, but decode them as 3f.
- Overflow committed: every digit shows a dash, 7'b1000000, until a non-overflowing value is committed.

## Timing
- Accept at edge N: `busy` is high after N. Commit and `busy` low happen at edge N+`BIN_W`.
- Earliest next accept is edge N+`BIN_W`+1. Load-to-load throughput is `BIN_W`+1 cycles.
- `sel`/`sseg` are registered and reflect the scan index and display register as of the previous edge, so a commit appears on the pins one cycle later.
- Each digit is selected for exactly `SCAN_DIV` cycles. A full refresh takes `DIGITS`×`SCAN_DIV` cycles.
- `reset` asserted mid-conversion aborts immediately. All state returns to the reset values, and nothing partial is committed.
- Conversion and scan are independent; a commit does not reset the scan index.

## Configuration
- `DISPLAY_BLANK_EN` defined: leading-zero blanking. Any digit above the most significant non-zero digit drives `sseg`=0. Digit 0 is never blanked, so value 0 shows a single "0". Dashes on overflow are never blanked.
- Undefined: all `DIGITS` digits are always driven, leading zeros included.

## Test plan
- Reset with defaults → `sel`=0001, `sseg`=3f, `busy`=0, `overflow`=0. Cycle `sel` 0001→0010→0100→1000→0001 with all digits 3f.
- Load 1234 → `busy` high for 13 cycles, then the scan shows 66,4f,5b,06 on `sel` 0001,0010,0100,1000. `load` pulsed mid-conversion with 9999 is ignored.
- Defaults with `DISPLAY_BLANK_EN`, load 7 → digit0=07, digits1–3=00. Without the macro, load 7 → 07,3f,3f,3f.
- `DIGITS`=3, `BIN_W`=10, load 1000 → `overflow`=1, all digits 40. Then load 999 → `overflow`=0, digits 6f,6f,6f.
- `SCAN_DIV`=3 → each `sel` pattern held exactly 3 cycles. Load 8191 (defaults) → 06,6f,06,7f.
- Assert `reset` at step 5 of converting 4321 → display register stays 0, `busy`=0, and the next load of 42 converts correctly in 13 cycles.
